// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and PC constants for the sequencer and next-PC logic
package pc_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_HALTED
`ifdef FETCH_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;
    localparam logic [31:0] PC_INCR = 32'd4;
    localparam logic [31:0] START_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection, PC+4 or PC+4+(imm32<<2) on a taken branch
module pc_next_calc
    import pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm32,
    input  logic        npc_sel,
    input  logic        zero,
    output logic [31:0] next_pc
);
    assign next_pc = pc + PC_INCR + ((npc_sel & zero) ? imm32 << 2 : 32'd0);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle PC controller with imem req/ack fetch; FETCH_TIMEOUT_EN adds fetch timeout and ERR state
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] START_PC = START_PC_DEFAULT
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        CLK,
    input  logic        MasterReset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        nPC_Sel,
    input  logic        zero,
    input  logic [31:0] imm32,
    input  logic        halt,
    output logic [31:0] PC,
    output logic        busy,
    output logic        fetch_err
);
    state_t      state;
    logic [31:0] next_pc;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`else
    assign fetch_err = 1'b0;
`endif

    pc_next_calc u_next (
        .pc      (PC),
        .imm32   (imm32),
        .npc_sel (nPC_Sel),
        .zero    (zero),
        .next_pc (next_pc)
    );

    assign imem_addr = PC;
    assign busy = (state == S_FETCH) || (state == S_LATCH) || (state == S_EXEC);

    // sequencing FSM: fetch handshake, instruction latch, PC update and restart
    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            state       <= S_IDLE;
            PC          <= START_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err   <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
                S_FETCH: if (imem_ack) begin
                    instr       <= imem_rdata;
                    instr_valid <= 1'b1;
                    imem_req    <= 1'b0;
                    state       <= S_LATCH;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state     <= S_ERR;
                    fetch_err <= 1'b1;
                    imem_req  <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
`endif
                S_LATCH: state <= S_EXEC;
                S_EXEC: if (exec_done) begin
                    PC       <= next_pc;
                    state    <= halt ? S_HALTED : S_FETCH;
                    imem_req <= ~halt;
`ifdef FETCH_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
                S_HALTED: if (start) begin
                    PC       <= START_PC;
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
`ifdef FETCH_TIMEOUT_EN
                S_ERR: state <= S_ERR;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + randomized bench for pc_sequencer against a PC arithmetic model
module tb_pc_sequencer;
    logic        CLK = 1'b0;
    logic        MasterReset, start, imem_ack, exec_done, nPC_Sel, zero, halt;
    logic [31:0] imem_rdata, imm32;
    logic        imem_req, instr_valid, busy, fetch_err;
    logic [31:0] imem_addr, instr, PC;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;

    pc_sequencer dut (
        .CLK(CLK), .MasterReset(MasterReset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done), .nPC_Sel(nPC_Sel),
        .zero(zero), .imm32(imm32), .halt(halt), .PC(PC), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet_chk(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_pc"}, PC, exp_pc);
        chk({tag, "_addr"}, imem_addr, exp_pc);
    endtask

    // one instruction from first FETCH cycle through the edge that samples exec_done
    task automatic do_instr(input int ad, input int dd, input logic br, input logic z,
                            input logic h, input logic [31:0] imm);
        logic [31:0] rd;
        rd = $urandom;
        for (int i = 0; i <= ad; i++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, exp_pc);
            chk("fetch_valid", instr_valid, 0);
            chk("fetch_busy", busy, 1);
            chk("fetch_err", fetch_err, 0);
            imem_ack = (i == ad);
            imem_rdata = (i == ad) ? rd : $urandom;
            exec_done = $urandom; start = $urandom; halt = $urandom;
            nPC_Sel = $urandom; zero = $urandom; imm32 = $urandom;
            @(negedge CLK);
        end
        chk("latch_valid", instr_valid, 1);
        chk("latch_instr", instr, rd);
        chk("latch_req", imem_req, 0);
        chk("latch_busy", busy, 1);
        chk("latch_pc", PC, exp_pc);
        imem_ack = $urandom; exec_done = $urandom; imem_rdata = $urandom;
        @(negedge CLK);
        for (int j = 0; j <= dd; j++) begin
            chk("exec_valid", instr_valid, 0);
            chk("exec_req", imem_req, 0);
            chk("exec_busy", busy, 1);
            chk("exec_pc", PC, exp_pc);
            chk("exec_instr", instr, rd);
            imem_ack = $urandom; start = $urandom;
            exec_done = (j == dd);
            nPC_Sel = (j == dd) ? br : 1'($urandom);
            zero = (j == dd) ? z : 1'($urandom);
            halt = (j == dd) ? h : 1'($urandom);
            imm32 = (j == dd) ? imm : $urandom;
            @(negedge CLK);
        end
        exp_pc = exp_pc + 32'd4 + ((br && z) ? imm * 32'd4 : 32'd0);
        exec_done = 0; imem_ack = 0; start = 0; halt = 0;
        if (h) quiet_chk("halted");
    endtask

    initial begin
        logic [31:0] imm;
        MasterReset = 1; start = 0; imem_ack = 0; exec_done = 0; nPC_Sel = 0;
        zero = 0; halt = 0; imem_rdata = 0; imm32 = 0;
        exp_pc = 32'h0;
        @(negedge CLK);
        @(negedge CLK);
        MasterReset = 0;
        quiet_chk("reset");
        chk("reset_instr", instr, 0);
        chk("reset_err", fetch_err, 0);
        exec_done = 1; imem_ack = 1;
        @(negedge CLK);
        quiet_chk("idle_hold");
        exec_done = 0; imem_ack = 0; start = 1;
        @(negedge CLK);
        start = 0;
        do_instr(0, 0, 0, 0, 0, 0);
        do_instr(0, 0, 0, 0, 0, 0);
        do_instr(0, 0, 1, 1, 0, 32'd3);
        chk("branch_taken_pc", exp_pc, 32'd24);
        do_instr(0, 0, 1, 0, 0, 32'd3);
        do_instr(0, 0, 1, 1, 0, 32'hFFFF_FFFE);
        do_instr(5, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            imm = $urandom_range(0, 64);
            imm = imm - 32'd32;
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 0, imm);
        end
        do_instr(1, 1, 1, 1, 1, 32'd2);
        for (int k = 0; k < 3; k++) begin
            exec_done = $urandom; imem_ack = $urandom;
            @(negedge CLK);
            quiet_chk("halted_hold");
        end
        exec_done = 0; imem_ack = 0; start = 1;
        @(negedge CLK);
        start = 0;
        exp_pc = 32'h0;
        do_instr(0, 0, 1, 1, 0, 32'hFFFF_FFFE);
        chk("wrap_pre", PC, 32'hFFFF_FFFC);
        do_instr(0, 0, 0, 0, 0, 0);
        chk("wrap_post", PC, 32'h0);
`ifndef FETCH_TIMEOUT_EN
        do_instr(20, 0, 0, 0, 0, 0);
`endif
        chk("mid_fetch_req", imem_req, 1);
        #2 MasterReset = 1;
        #1;
        exp_pc = 32'h0;
        quiet_chk("async_rst");
        chk("async_rst_instr", instr, 0);
        @(negedge CLK);
        MasterReset = 0;
        @(negedge CLK);
        quiet_chk("post_rst_idle");
`ifdef FETCH_TIMEOUT_EN
        start = 1;
        @(negedge CLK);
        start = 0;
        for (int i = 0; i < 16; i++) begin
            chk("to_req", imem_req, 1);
            chk("to_err_low", fetch_err, 0);
            @(negedge CLK);
        end
        chk("to_err", fetch_err, 1);
        chk("to_req_drop", imem_req, 0);
        chk("to_busy", busy, 0);
        imem_ack = 1; start = 1; exec_done = 1;
        @(negedge CLK);
        @(negedge CLK);
        chk("to_sticky", fetch_err, 1);
        chk("to_late_ack_req", imem_req, 0);
        chk("to_late_ack_valid", instr_valid, 0);
        imem_ack = 0; start = 0; exec_done = 0;
        MasterReset = 1;
        #1;
        chk("to_rst_clear", fetch_err, 0);
        @(negedge CLK);
        MasterReset = 0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter controller for the single-issue core. It owns the PC register and issues one instruction-fetch request per instruction over a req/ack handshake to instruction memory. It then presents the fetched word to decode/execute and waits for execution to finish. Finally it selects the next PC: PC+4, or PC+4+(imm32<<2) for a taken branch. It sits between instruction memory and the decode/execute datapath and replaces free-running, every-edge PC update with explicit sequencing.

## Interface
- START_PC, 32'h0000_0000: PC value loaded on reset and on restart from HALTED.
- TIMEOUT_CYCLES, 16: maximum cycles in FETCH without imem_ack. Used only with FETCH_TIMEOUT_EN.

Ports:
- CLK  in  1  rising-edge clock
- MasterReset  in  1  asynchronous, active-high reset
- start  in  1  leaves IDLE/HALTED; sampled in those states only
- imem_req  out  1  fetch request; held until ack
- imem_addr  out  32  fetch address; equals PC while imem_req=1
- imem_ack  in  1  memory accepted request; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  latched instruction
- instr_valid  out  1  one-cycle pulse when instr updates
- exec_done  in  1  execute stage finished current instruction
- nPC_Sel  in  1  current instruction is a branch; sampled with exec_done
- zero  in  1  ALU zero flag; sampled with exec_done
- imm32  in  32  sign-extended branch offset in words; sampled with exec_done
- halt  in  1  stop after current instruction; sampled with exec_done
- PC  out  32  current program counter
- busy  out  1  high in FETCH, LATCH, EXEC
- fetch_err  out  1  sticky timeout flag; constant 0 without FETCH_TIMEOUT_EN

## Operation
- States: IDLE, FETCH, LATCH, EXEC, HALTED, and ERR (ERR exists only with the macro).
- IDLE:
  - start=1 → FETCH.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - imem_ack=1 → capture imem_rdata into instr, go to LATCH.
- LATCH:
  - instr_valid=1 for this single cycle, then → EXEC.
- EXEC:
  - Wait for exec_done.
  - When exec_done=1, update PC:
    - taken = nPC_Sel & zero.
    - Not taken: PC ← PC+4.
    - Taken: PC ← PC+4+{imm32[29:0],2'b00}.
  - Next state: halt=1 → HALTED, else → FETCH.
- PC arithmetic is 32-bit modulo 2^32. Wrap-around is silent: 32'hFFFF_FFFC+4 = 0.
- HALTED:
  - PC holds its value.
  - start=1 → PC ← START_PC, → FETCH.
- Simultaneous events:
  - exec_done with halt and a taken branch: PC updates to the branch target, then HALTED.
  - start while in FETCH/LATCH/EXEC is ignored.
- imem_ack outside FETCH is ignored.
- exec_done outside EXEC is ignored.

## Timing
- Reset (asynchronous, any state, including mid-handshake):
  - State=IDLE, PC=START_PC, instr=0.
  - imem_req=0, instr_valid=0, busy=0, fetch_err=0.
  - imem_addr is driven from PC, so it resets to START_PC.
- Minimum 3 cycles per instruction: FETCH(ack in first cycle) → LATCH → EXEC(exec_done in first cycle).
- Latencies:
  - PC changes on the rising edge that samples exec_done.
  - imem_req rises in the following cycle with the new PC.
  - instr_valid pulses one cycle after the edge that samples imem_ack.
- Handshake:
  - imem_req rises and stays high until the edge where imem_ack=1 is sampled.
  - imem_addr is stable throughout.
  - imem_req drops the cycle after ack.
- All outputs are registered except imem_addr (a wire from PC) and busy (a decode of state).

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES: → ERR, fetch_err ← 1, imem_req ← 0.
  - ERR is left only by MasterReset.
- FETCH_TIMEOUT_EN undefined:
  - No counter and no ERR state. FETCH waits indefinitely.
  - fetch_err is tied to 0.

## Structure
- Shared package pc_pkg holds:
  - the state enum type
  - the constant PC_INCR=4
  - the default START_PC
- One sub-module, pc_next_calc: combinational next-PC selection (PC, imm32, nPC_Sel, zero → next_pc).
  - It is reused by the single-cycle path and by this sequencer.
- FSM, handshake, and timeout counter live in pc_sequencer.

## Test plan
- Reset then start, ack immediately, exec_done with nPC_Sel=0 → imem_addr sequence 0,4,8; instr_valid pulses every 3 cycles.
- At PC=8, exec_done with nPC_Sel=1, zero=1, imm32=3 → next imem_addr=24. Repeat with zero=0 → 12. With imm32=-2 (32'hFFFF_FFFE) at PC=16 → 12.
- Delay ack 5 cycles → imem_req high 6 cycles, imem_addr constant, single instr_valid pulse with captured rdata.
- exec_done with halt=1 at PC=4 → PC=8, HALTED, busy=0. Then start → PC=START_PC, FETCH.
- Assert MasterReset mid-FETCH with imem_req=1 → same-cycle imem_req=0, PC=START_PC, state IDLE.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → fetch_err=1 after 16 FETCH cycles, imem_req=0. A late ack is ignored; only reset clears fetch_err.
